// File: rtl/pxl_conv_pkg.sv
// -----------------------------------------------------------------------------
// pxl_conv_pkg
// Shared types and helpers for the grayscale-to-colour pixel converter.
//   mode_e     : colour mode encodings (reserved code behaves as RGB565)
//   state_e    : converter FSM states
//   nb()       : number of DBI beats per pixel for a mode / bus width
//   expand_g8(): left-align a gray pixel to 8 bits with MSB replication
// -----------------------------------------------------------------------------
package pxl_conv_pkg;

   typedef enum logic [1:0] {
      MODE_RGB565 = 2'd0,
      MODE_RGB666 = 2'd1,
      MODE_RGB888 = 2'd2,
      MODE_RSVD   = 2'd3
   } mode_e;

   typedef enum logic {
      ST_IDLE,
      ST_SEND
   } state_e;

   // Beats per pixel: 8-bit bus needs 2 (565) or 3 (666/888),
   // 16-bit bus needs 1 (565) or 2 (666/888).
   function automatic logic [1:0] nb(input mode_e mode, input int unsigned bus_w);
      logic wide_mode;
      wide_mode = (mode == MODE_RGB666) || (mode == MODE_RGB888);
      if (bus_w == 16) return wide_mode ? 2'd2 : 2'd1;
      return wide_mode ? 2'd3 : 2'd2;
   endfunction

   // gray is zero-extended from w bits (4..8). After left alignment the
   // vacated LSBs are refilled from the top bits; since w >= 4 a single
   // shifted copy always covers the 8-w hole (4-bit 0xA -> 0xAA).
   function automatic logic [7:0] expand_g8(input logic [7:0] gray, input int unsigned w);
      logic [7:0] aligned;
      aligned = gray << (8 - w);
      return aligned | (aligned >> w);
   endfunction

endpackage

// File: rtl/pxl_fmt_conv_if.sv
// -----------------------------------------------------------------------------
// pxl_fmt_conv_if
// Handshake bundle around the converter: gray pixel stream in, DBI beat
// stream out. Signal suffixes are from the converter's point of view.
//   slave  : converter side (consumes gray pixels, produces beats)
//   master : environment side (FIFO producer + DBI TX FSM consumer)
// -----------------------------------------------------------------------------
interface pxl_fmt_conv_if #(
   parameter int GRAY_PXL_W = 8,
   parameter int DBI_BUS_W  = 8
) ();

   logic [GRAY_PXL_W-1:0] gray_pxl_dat_i;
   logic                  gray_pxl_vld_i;
   logic                  gray_pxl_rdy_o;
   logic [DBI_BUS_W-1:0]  rgb_pxl_dat_o;
   logic                  rgb_pxl_vld_o;
   logic                  rgb_pxl_rdy_i;

   modport slave (
      input  gray_pxl_dat_i, gray_pxl_vld_i, rgb_pxl_rdy_i,
      output gray_pxl_rdy_o, rgb_pxl_dat_o, rgb_pxl_vld_o
   );

   modport master (
      output gray_pxl_dat_i, gray_pxl_vld_i, rgb_pxl_rdy_i,
      input  gray_pxl_rdy_o, rgb_pxl_dat_o, rgb_pxl_vld_o
   );

endinterface

// File: rtl/pxl_fmt_pack.sv
// -----------------------------------------------------------------------------
// pxl_fmt_pack
// Combinational beat formatter: selects the DBI beat for the held pixel.
//   g8   in  8          normalised gray pixel
//   mode in  mode_e     colour mode (reserved already folded to RGB565)
//   beat in  2          beat index within the pixel
//   dat  out DBI_BUS_W  beat data
// -----------------------------------------------------------------------------
module pxl_fmt_pack
   import pxl_conv_pkg::*;
#(
   parameter int DBI_BUS_W = 8
) (
   input  logic [7:0]           g8,
   input  mode_e                mode,
   input  logic [1:0]           beat,
   output logic [DBI_BUS_W-1:0] dat
);

   logic [4:0] c5;
   logic [5:0] c6;

   assign c5 = g8[7:3];
   assign c6 = g8[7:2];

   if (DBI_BUS_W == 16) begin : g_bus16
      always_comb begin
         case (mode)
            MODE_RGB666: dat = (beat == 2'd0) ? {c6, 2'b00, c6, 2'b00} : {c6, 2'b00, 8'h00};
            MODE_RGB888: dat = (beat == 2'd0) ? {g8, g8} : {g8, 8'h00};
            default:     dat = {c5, c6, c5};
         endcase
      end
   end else begin : g_bus8
      always_comb begin
         case (mode)
            MODE_RGB666: dat = {c6, 2'b00};
            MODE_RGB888: dat = g8;
            default:     dat = (beat == 2'd0) ? {c5, c6[5:3]} : {c6[2:0], c5};
         endcase
      end
   end

endmodule

// File: rtl/pxl_fmt_conv.sv
// -----------------------------------------------------------------------------
// pxl_fmt_conv
// Gray-to-RGB565/666/888 converter and DBI bus serializer. Holds one pixel
// and emits it as 1..3 beats, accepting the next pixel on the cycle of the
// last beat handshake so a stream runs at one beat per cycle.
//   clk            in   clock
//   rst_n          in   asynchronous active-low reset
//   mode_i         in   colour mode, sampled when a pixel is loaded
//   bus            slave gray pixel in / DBI beat out handshakes
//   frm_pxl_cnt_o  out  pixels completed in current frame
//   frm_done_o     out  one-cycle pulse after the last pixel of a frame
// Optional: define PXL_CONV_FRM_CNT_EN to build the frame counter; otherwise
// frm_pxl_cnt_o and frm_done_o are tied low.
// -----------------------------------------------------------------------------
module pxl_fmt_conv
   import pxl_conv_pkg::*;
#(
   parameter int GRAY_PXL_W  = 8,
   parameter int DBI_BUS_W   = 8,
   parameter int FRM_PXL_NUM = 76800
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [1:0]                     mode_i,
   pxl_fmt_conv_if.slave                  bus,
   output logic [$clog2(FRM_PXL_NUM)-1:0] frm_pxl_cnt_o,
   output logic                           frm_done_o
);

   state_e               state_q;
   logic [1:0]           beat_q;
   logic [7:0]           g8_q;
   mode_e                mode_q;
   logic [DBI_BUS_W-1:0] pack_dat;

   logic vld;
   logic last_beat;
   logic beat_hs;
   logic last_hs;
   logic gray_rdy;
   logic gray_hs;

   // Beat valid comes only from state, so it never waits on the consumer;
   // gray ready is allowed to see rgb_pxl_rdy_i so a new pixel can load on
   // the same edge the last beat leaves.
   assign vld       = (state_q == ST_SEND);
   assign last_beat = (beat_q == nb(mode_q, DBI_BUS_W) - 2'd1);
   assign beat_hs   = vld & bus.rgb_pxl_rdy_i;
   assign last_hs   = beat_hs & last_beat;
   assign gray_rdy  = (state_q == ST_IDLE) | last_hs;
   assign gray_hs   = bus.gray_pxl_vld_i & gray_rdy;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         beat_q  <= 2'd0;
         g8_q    <= 8'h00;
         mode_q  <= MODE_RGB565;
      end else if (gray_hs) begin
         state_q <= ST_SEND;
         beat_q  <= 2'd0;
         g8_q    <= expand_g8(8'(bus.gray_pxl_dat_i), GRAY_PXL_W);
         mode_q  <= (mode_i == MODE_RSVD) ? MODE_RGB565 : mode_e'(mode_i);
      end else if (last_hs) begin
         state_q <= ST_IDLE;
         beat_q  <= 2'd0;
      end else if (beat_hs) begin
         beat_q  <= beat_q + 2'd1;
      end
   end

   pxl_fmt_pack #(
      .DBI_BUS_W (DBI_BUS_W)
   ) u_pack (
      .g8   (g8_q),
      .mode (mode_q),
      .beat (beat_q),
      .dat  (pack_dat)
   );

   // Data is a pure function of held registers, so it cannot move while the
   // consumer stalls; after reset the held pixel is zero, giving zero data.
   assign bus.rgb_pxl_dat_o  = pack_dat;
   assign bus.rgb_pxl_vld_o  = vld;
   assign bus.gray_pxl_rdy_o = gray_rdy;

`ifdef PXL_CONV_FRM_CNT_EN
   localparam int CNT_W = $clog2(FRM_PXL_NUM);

   logic [CNT_W-1:0] cnt_q;
   logic             done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else if (last_hs) begin
         if (cnt_q == CNT_W'(FRM_PXL_NUM - 1)) begin
            cnt_q  <= '0;
            done_q <= 1'b1;
         end else begin
            cnt_q  <= cnt_q + CNT_W'(1);
            done_q <= 1'b0;
         end
      end else begin
         done_q <= 1'b0;
      end
   end

   assign frm_pxl_cnt_o = cnt_q;
   assign frm_done_o    = done_q;
`else
   assign frm_pxl_cnt_o = '0;
   assign frm_done_o    = 1'b0;
`endif

endmodule

// File: tb/tb_pxl_fmt_conv.sv
// -----------------------------------------------------------------------------
// tb_pxl_fmt_conv
// Directed bench for pxl_fmt_conv. Two instances: an 8-bit gray / 8-bit bus
// converter with a 4-pixel frame, and a 4-bit gray / 16-bit bus converter.
// -----------------------------------------------------------------------------
module tb_pxl_fmt_conv;

   logic        clk;
   logic        rst_n;
   logic [1:0]  mode8;
   logic [1:0]  mode16;
   logic [1:0]  cnt8;
   logic        done8;
   logic [16:0] cnt16;
   logic        done16;

   int checks   = 0;
   int failures = 0;

   pxl_fmt_conv_if #(.GRAY_PXL_W(8), .DBI_BUS_W(8))  if8 ();
   pxl_fmt_conv_if #(.GRAY_PXL_W(4), .DBI_BUS_W(16)) if16 ();

   pxl_fmt_conv #(.GRAY_PXL_W(8), .DBI_BUS_W(8), .FRM_PXL_NUM(4)) dut8 (
      .clk           (clk),
      .rst_n         (rst_n),
      .mode_i        (mode8),
      .bus           (if8),
      .frm_pxl_cnt_o (cnt8),
      .frm_done_o    (done8)
   );

   pxl_fmt_conv #(.GRAY_PXL_W(4), .DBI_BUS_W(16)) dut16 (
      .clk           (clk),
      .rst_n         (rst_n),
      .mode_i        (mode16),
      .bus           (if16),
      .frm_pxl_cnt_o (cnt16),
      .frm_done_o    (done16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one pixel to an idle converter with the consumer always ready and
   // check each beat; returns just after the edge of the last beat handshake.
   task automatic run_pixel(input bit sel16, input logic [7:0] g, input logic [1:0] m,
                            input int n, input logic [15:0] b0, input logic [15:0] b1,
                            input logic [15:0] b2, input string tag);
      logic [15:0] exp_b [3];
      exp_b[0] = b0;
      exp_b[1] = b1;
      exp_b[2] = b2;
      if (sel16) begin
         if16.gray_pxl_dat_i = g[3:0];
         if16.gray_pxl_vld_i = 1'b1;
         if16.rgb_pxl_rdy_i  = 1'b1;
         mode16              = m;
      end else begin
         if8.gray_pxl_dat_i  = g;
         if8.gray_pxl_vld_i  = 1'b1;
         if8.rgb_pxl_rdy_i   = 1'b1;
         mode8               = m;
      end
      #1;
      check({tag, "_load_rdy"}, sel16 ? if16.gray_pxl_rdy_o : if8.gray_pxl_rdy_o, 1);
      tick();
      if16.gray_pxl_vld_i = 1'b0;
      if8.gray_pxl_vld_i  = 1'b0;
      for (int i = 0; i < n; i++) begin
         #1;
         check({tag, "_vld"}, sel16 ? if16.rgb_pxl_vld_o : if8.rgb_pxl_vld_o, 1);
         check({tag, "_dat"}, sel16 ? if16.rgb_pxl_dat_o : 16'(if8.rgb_pxl_dat_o), exp_b[i]);
         tick();
      end
      #1;
      check({tag, "_end_vld"}, sel16 ? if16.rgb_pxl_vld_o : if8.rgb_pxl_vld_o, 0);
   endtask

   initial begin
      logic [7:0] q[$];
      logic [7:0] pix;
      logic [7:0] prev_dat;
      logic       prev_stall;
      logic       exp_grdy;
      int         sent;
      int         cyc;
      logic [1:0] exp_cnt;
      logic       exp_done;

      rst_n  = 1'b0;
      mode8  = 2'd0;
      mode16 = 2'd0;
      if8.gray_pxl_dat_i  = '0;
      if8.gray_pxl_vld_i  = 1'b0;
      if8.rgb_pxl_rdy_i   = 1'b0;
      if16.gray_pxl_dat_i = '0;
      if16.gray_pxl_vld_i = 1'b0;
      if16.rgb_pxl_rdy_i  = 1'b0;

      // Reset values
      #3;
      check("rst_vld8",   if8.rgb_pxl_vld_o, 0);
      check("rst_dat8",   if8.rgb_pxl_dat_o, 0);
      check("rst_grdy8",  if8.gray_pxl_rdy_o, 1);
      check("rst_cnt8",   cnt8, 0);
      check("rst_done8",  done8, 0);
      check("rst_vld16",  if16.rgb_pxl_vld_o, 0);
      check("rst_dat16",  if16.rgb_pxl_dat_o, 0);
      check("rst_grdy16", if16.gray_pxl_rdy_o, 1);
      check("rst_cnt16",  cnt16, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // 8-bit bus, each mode
      run_pixel(0, 8'h80, 2'd0, 2, 16'h84, 16'h10, 16'h00, "b8_565_80");
      run_pixel(0, 8'hFF, 2'd0, 2, 16'hFF, 16'hFF, 16'h00, "b8_565_ff");
      run_pixel(0, 8'h5A, 2'd1, 3, 16'h58, 16'h58, 16'h58, "b8_666_5a");
      run_pixel(0, 8'h5A, 2'd2, 3, 16'h5A, 16'h5A, 16'h5A, "b8_888_5a");
      run_pixel(0, 8'h80, 2'd3, 2, 16'h84, 16'h10, 16'h00, "b8_rsvd_80");

      // 4-bit gray, 16-bit bus
      run_pixel(1, 8'h0A, 2'd0, 1, 16'hAD55, 16'h0000, 16'h0000, "b16_565_a");
      run_pixel(1, 8'h0A, 2'd2, 2, 16'hAAAA, 16'hAA00, 16'h0000, "b16_888_a");
      run_pixel(1, 8'h05, 2'd1, 2, 16'h5454, 16'h5400, 16'h0000, "b16_666_5");

      // Stall, mode change mid-pixel, back-to-back reload
      mode8 = 2'd0;
      if8.gray_pxl_dat_i = 8'h80;
      if8.gray_pxl_vld_i = 1'b1;
      if8.rgb_pxl_rdy_i  = 1'b0;
      #1;
      check("st_load_rdy", if8.gray_pxl_rdy_o, 1);
      tick();
      if8.gray_pxl_dat_i = 8'h5A;
      mode8 = 2'd2;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("st_stall_vld",  if8.rgb_pxl_vld_o, 1);
         check("st_stall_dat",  if8.rgb_pxl_dat_o, 8'h84);
         check("st_stall_grdy", if8.gray_pxl_rdy_o, 0);
         tick();
      end
      if8.rgb_pxl_rdy_i = 1'b1;
      #1;
      check("st_b0_dat",  if8.rgb_pxl_dat_o, 8'h84);
      check("st_b0_grdy", if8.gray_pxl_rdy_o, 0);
      tick();
      #1;
      check("st_b1_dat",  if8.rgb_pxl_dat_o, 8'h10);
      check("st_b1_grdy", if8.gray_pxl_rdy_o, 1);
      tick();
      if8.gray_pxl_vld_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("st_next_vld",  if8.rgb_pxl_vld_o, 1);
         check("st_next_dat",  if8.rgb_pxl_dat_o, 8'h5A);
         check("st_next_grdy", if8.gray_pxl_rdy_o, (i == 2) ? 1 : 0);
         tick();
      end
      #1;
      check("st_end_vld", if8.rgb_pxl_vld_o, 0);

      // Random consumer stalls over 100 RGB888 pixels against a beat queue
      mode8      = 2'd2;
      sent       = 0;
      cyc        = 0;
      prev_stall = 1'b0;
      prev_dat   = 8'h00;
      pix        = 8'($urandom_range(0, 255));
      while ((sent < 100 || q.size() != 0) && cyc < 3000) begin
         if8.rgb_pxl_rdy_i  = 1'($urandom_range(0, 1));
         if8.gray_pxl_vld_i = (sent < 100);
         if8.gray_pxl_dat_i = pix;
         #1;
         exp_grdy = (q.size() == 0) || (q.size() == 1 && if8.rgb_pxl_rdy_i);
         check("rnd_vld",  if8.rgb_pxl_vld_o, (q.size() != 0));
         check("rnd_grdy", if8.gray_pxl_rdy_o, exp_grdy);
         if (prev_stall) check("rnd_hold", if8.rgb_pxl_dat_o, prev_dat);
         prev_stall = (q.size() != 0) && !if8.rgb_pxl_rdy_i;
         prev_dat   = if8.rgb_pxl_dat_o;
         if (q.size() != 0 && if8.rgb_pxl_rdy_i) begin
            check("rnd_dat", if8.rgb_pxl_dat_o, q[0]);
            void'(q.pop_front());
         end
         if (if8.gray_pxl_vld_i && exp_grdy) begin
            q.push_back(pix);
            q.push_back(pix);
            q.push_back(pix);
            sent++;
            pix = 8'($urandom_range(0, 255));
         end
         cyc++;
         tick();
      end
      if8.gray_pxl_vld_i = 1'b0;
      if8.rgb_pxl_rdy_i  = 1'b1;
      check("rnd_sent",    sent, 100);
      check("rnd_drained", q.size(), 0);

      // Reset during beat 2 of an RGB888 pixel
      mode8 = 2'd2;
      if8.gray_pxl_dat_i = 8'h5A;
      if8.gray_pxl_vld_i = 1'b1;
      #1;
      tick();
      if8.gray_pxl_vld_i = 1'b0;
      tick();
      tick();
      #1;
      check("mr_pre_vld", if8.rgb_pxl_vld_o, 1);
      check("mr_pre_dat", if8.rgb_pxl_dat_o, 8'h5A);
      rst_n = 1'b0;
      #1;
      check("mr_vld",  if8.rgb_pxl_vld_o, 0);
      check("mr_grdy", if8.gray_pxl_rdy_o, 1);
      check("mr_dat",  if8.rgb_pxl_dat_o, 0);
      tick();
      rst_n = 1'b1;
      tick();
      run_pixel(0, 8'h80, 2'd0, 2, 16'h84, 16'h10, 16'h00, "mr_after");

      // Frame counter over a 4-pixel frame
      rst_n = 1'b0;
      #1;
      check("frm_rst_cnt", cnt8, 0);
      tick();
      rst_n = 1'b1;
      tick();
      for (int p = 1; p <= 4; p++) begin
         run_pixel(0, 8'(p * 16), 2'd2, 3, 16'(p * 16), 16'(p * 16), 16'(p * 16), "frm_pix");
`ifdef PXL_CONV_FRM_CNT_EN
         exp_cnt  = 2'(p % 4);
         exp_done = (p == 4);
`else
         exp_cnt  = 2'd0;
         exp_done = 1'b0;
`endif
         check("frm_cnt",  cnt8, exp_cnt);
         check("frm_done", done8, exp_done);
      end
      tick();
      #1;
      check("frm_done_clr", done8, 0);
      check("frm_cnt_hold", cnt8, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pxl_fmt_conv.md
# pxl_fmt_conv

Parametrised grayscale-to-colour pixel converter and bus serializer in the display TX path, between the pixel AXI4 FIFO and the DBI TX FSM. Accepts one gray pixel per handshake, expands it to RGB565, RGB666 or RGB888 with MSB-correct bit replication, and emits it as 1–3 beats on an 8- or 16-bit DBI data bus. Fully registered pixel holding stage with back-to-back throughput of one beat per cycle.

## Interface
- GRAY_PXL_W, 8, gray pixel width, legal 4..8
- DBI_BUS_W, 8, output beat width, legal 8 or 16
- FRM_PXL_NUM, 76800, pixels per frame (used only with PXL_CONV_FRM_CNT_EN)
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- mode_i  input  2  colour mode: 0 RGB565, 1 RGB666, 2 RGB888, 3 reserved (treated as RGB565)
- gray_pxl_dat_i  input  GRAY_PXL_W  gray pixel from FIFO
- gray_pxl_vld_i  input  1  gray pixel valid
- gray_pxl_rdy_o  output  1  converter ready for gray pixel
- rgb_pxl_dat_o  output  DBI_BUS_W  beat data to DBI TX FSM
- rgb_pxl_vld_o  output  1  beat valid
- rgb_pxl_rdy_i  input  1  DBI TX FSM ready
- frm_pxl_cnt_o  output  $clog2(FRM_PXL_NUM)  pixels completed in current frame (macro only)
- frm_done_o  output  1  one-cycle frame-complete pulse (macro only)

## Operation
- Normalize: g8 = gray left-aligned to 8 bits, vacated LSBs filled by repeating gray MSBs (4-bit 0xA → 0xAA).
- Channels: c5 = g8[7:3], c6 = g8[7:2], c8 = g8.
- 8-bit bus: RGB565 2 beats {c5,c6[5:3]}, {c6[2:0],c5}; RGB666 3 beats {c6,2'b00} each; RGB888 3 beats c8 each.
- 16-bit bus: RGB565 1 beat {c5,c6,c5}; RGB666 2 beats {c6,2'b00,c6,2'b00}, {c6,2'b00,8'h00}; RGB888 2 beats {c8,c8}, {c8,8'h00}.
- States: IDLE (no pixel held), SEND (pixel held, beat index 0..NB-1).
- IDLE: gray_pxl_rdy_o=1; on gray handshake latch g8 and mode_i, beat=0, go SEND.
- SEND: rgb_pxl_vld_o=1; on beat handshake beat++; on last beat handshake: if gray handshake same cycle, reload and stay SEND with beat=0, else IDLE.
- gray_pxl_rdy_o = IDLE | (SEND & last beat & rgb_pxl_rdy_i).
- mode_i sampled only at pixel load; changes mid-pixel affect next pixel only.
- rgb_pxl_dat_o held stable while vld high and rdy low.

## Timing
- Reset: state IDLE, beat 0, held pixel 0, rgb_pxl_vld_o 0, rgb_pxl_dat_o 0, gray_pxl_rdy_o 1, frm_pxl_cnt_o 0, frm_done_o 0.
- Latency: gray handshake in cycle N → first beat valid in N+1.
- Throughput: one beat per cycle with rgb_pxl_rdy_i high; no bubble between pixels.
- rgb_pxl_vld_o never depends combinationally on rgb_pxl_rdy_i; gray_pxl_rdy_o does.
- Reset asserted mid-pixel: partial pixel discarded, outputs to reset values immediately.

## Configuration
- PXL_CONV_FRM_CNT_EN defined: counter increments on each last-beat handshake; at FRM_PXL_NUM-1 it wraps to 0 and frm_done_o pulses high the following cycle for one cycle.
- Undefined: counter logic absent, frm_pxl_cnt_o and frm_done_o tied 0.

## Structure
- Package pxl_conv_pkg: mode encodings (MODE_RGB565/666/888), beat-count function nb(mode, bus_w), g8 expansion function.
- Sub-module pxl_fmt_pack: combinational (g8, mode, beat) → beat data mux; top holds FSM, registers, counter.

## Test plan
- 8-bit bus, RGB565, gray 0x80 → beats 0x84, 0x10; gray 0xFF → 0xFF, 0xFF.
- 8-bit bus, RGB666, gray 0x5A → 0x58 ×3; RGB888 gray 0x5A → 0x5A ×3.
- GRAY_PXL_W=4, DBI_BUS_W=16, RGB565, gray 0xA → single beat 0xAD55.
- rgb_pxl_rdy_i toggled randomly over 100 RGB888 pixels → no beat lost/duplicated, data stable under stall, gray_pxl_rdy_o only on last-beat handshake.
- Continuous stream, rdy held 1, RGB565 8-bit → vld high every cycle, new pixel loaded same cycle as previous last beat; mode_i changed mid-pixel → takes effect next pixel.
- Reset mid-RGB888 pixel after beat 1 → vld 0, rdy 1; with macro, FRM_PXL_NUM=4 → frm_done_o single pulse after 4th pixel, count wraps to 0.
